inst_encoder: RTL

Instruction encoder for the single-cycle RV32I datapath: the inverse of the immediate generator. Accepts decoded fields (opcode, register indices, funct codes, 32-bit immediate), packs them into a 32-bit instruction word, and emits it with a sequential write address for loading instruction memory. Used by the program loader and the self-checking bench to build programs whose immediates round-trip exactly through the datapath's immediate generator.

---
 rtl/inst_encoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word behind a
// single-entry valid/ready output register with a sequential load address.
module inst_encoder #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] addr,
  output logic              err,
  output logic              err_sticky,
  output logic [15:0]       word_count
);

  localparam logic [31:0]       NOP  = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_SB, FMT_UJ, FMT_U, FMT_BAD
  } fmt_e;

  fmt_e        w_fmt;
  logic        w_ext11, w_ext12, w_ext20, w_ext19;
  logic        w_ok;
  logic [31:0] w_packed;
  logic [31:0] w_enc_inst;
  logic        w_enc_err;
  logic        w_in_hs, w_out_hs;

  logic              r_out_valid;
  logic [31:0]       r_inst;
  logic              r_err;
  logic              r_err_sticky;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_word_count;

  // Sign-extension checks: upper bits must be a pure copy of the field's top bit.
  assign w_ext11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign w_ext12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign w_ext20 = (&imm[31:20]) | ~(|imm[31:20]);
  assign w_ext19 = (&imm[31:19]) | ~(|imm[31:19]);

  always_comb begin
    w_fmt = FMT_BAD;
    case (opcode)
      7'b1101111:             w_fmt = FMT_UJ;
      7'b1100011:             w_fmt = FMT_SB;
      7'b0100011:             w_fmt = FMT_S;
      7'b0010011, 7'b0000011: w_fmt = FMT_I;
      7'b0110111, 7'b0010111: w_fmt = FMT_U;
      7'b0110011:             w_fmt = FMT_R;
      default:                w_fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    w_ok     = 1'b0;
    w_packed = NOP;
    case (w_fmt)
      FMT_R: begin
        w_ok     = 1'b1;
        w_packed = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        w_ok     = w_ext11;
        w_packed = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: begin
        w_ok     = w_ext11;
        w_packed = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      FMT_SB: begin
        w_ok     = w_ext12 & ~imm[0];
        w_packed = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      FMT_UJ: begin
        w_ok     = w_ext20 & ~imm[0];
        w_packed = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      FMT_U: begin
        w_ok     = w_ext19;
        w_packed = {imm[19:0], rd, opcode};
      end
      default: begin
        w_ok     = 1'b0;
        w_packed = NOP;
      end
    endcase
    w_enc_err  = ~w_ok;
    w_enc_inst = w_ok ? w_packed : NOP;
  end

  assign in_ready = ~r_out_valid | out_ready;
  assign w_in_hs  = in_valid & in_ready;
  assign w_out_hs = r_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_inst       <= '0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_addr       <= BASE;
      r_word_count <= '0;
    end else begin
      if (w_in_hs) begin
        r_inst <= w_enc_inst;
        r_err  <= w_enc_err;
        if (w_enc_err) r_err_sticky <= 1'b1;
      end
      // addr tracks words handed off, so a word loaded alongside a handoff
      // is presented at the advanced address.
      if (w_out_hs) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (r_word_count != '1) r_word_count <= r_word_count + 16'd1;
      end
      if (w_in_hs)       r_out_valid <= 1'b1;
      else if (w_out_hs) r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign inst       = r_inst;
  assign addr       = r_addr;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;
  assign word_count = r_word_count;

endmodule
